// File: rtl/ps2_band_selector_pkg.sv
// ps2_band_selector_pkg: shared definitions for the PS/2 band selector front end.
//   - PS/2 set-2 scan-code constants used by the decoder
//   - decoder FSM state encoding
//   - band encodings and wrap-around step helpers
package ps2_band_selector_pkg;

  localparam logic [7:0] SC_BRK = 8'hF0;  // break prefix
  localparam logic [7:0] SC_EXT = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_K1  = 8'h16;  // '1'
  localparam logic [7:0] SC_K2  = 8'h1E;  // '2'
  localparam logic [7:0] SC_K3  = 8'h26;  // '3'
  localparam logic [7:0] SC_K0  = 8'h45;  // '0'
  localparam logic [7:0] SC_UP  = 8'h75;  // up arrow (after E0)
  localparam logic [7:0] SC_DN  = 8'h72;  // down arrow (after E0)

  localparam logic [1:0] BAND1 = 2'd0;
  localparam logic [1:0] BAND2 = 2'd1;
  localparam logic [1:0] BAND3 = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } ps2_state_e;

  function automatic logic [1:0] band_up(input logic [1:0] band);
    return (band == BAND3) ? BAND1 : band + 2'd1;
  endfunction

  function automatic logic [1:0] band_dn(input logic [1:0] band);
    return (band == BAND1) ? BAND3 : band - 2'd1;
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// ps2_seq_timer: inter-byte timeout counter for PS/2 prefix sequences.
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   clr_i    - synchronous clear (takes priority over en_i)
//   en_i     - count one cycle
//   expire_o - high while the count sits at TIMEOUT-1
module ps2_seq_timer #(
  parameter int unsigned TIMEOUT = 2500000,
  parameter int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_d, cnt_q;

  assign expire_o = (cnt_q == LastCnt);

  // Saturate at the terminal count so expire_o stays high until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_band_selector.sv
// ps2_band_selector: decodes PS/2 scan-code bytes into a registered band select and mute flag.
//   clk_i    - system clock
//   rst_i    - asynchronous active-low reset
//   rx_listo - one-cycle strobe, data_i holds a complete received byte
//   data_i   - scan-code byte
//   band_o   - selected band (0..2)
//   mute_o   - 1 = output muted
//   chg_o    - one-cycle pulse when band_o or mute_o changes
// Optional build macro KEY_REPEAT_FILTER_EN: ignores typematic repeats of the last make key
// until its break code arrives.
module ps2_band_selector
  import ps2_band_selector_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2500000,
  parameter int unsigned TO_W    = $clog2(TIMEOUT)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_listo,
  input  logic [7:0] data_i,
  output logic [1:0] band_o,
  output logic       mute_o,
  output logic       chg_o
);

  ps2_state_e state_d, state_q;
  logic [1:0] band_d, band_q;
  logic       mute_d, mute_q;
  logic       chg_d, chg_q;
  logic       expire;
  logic       make_vld;
  logic [8:0] make_key;  // {extended, code}
  logic       make_rpt;

  // Timer only runs while waiting for the byte that follows a prefix.
  ps2_seq_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_seq_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .clr_i    ((state_q == StIdle) || rx_listo),
    .en_i     ((state_q != StIdle) && !rx_listo),
    .expire_o (expire)
  );

`ifdef KEY_REPEAT_FILTER_EN
  logic [8:0] held_d, held_q;
  logic       brk_vld;
  logic [8:0] brk_key;
  assign make_rpt = (held_q == make_key);
`else
  assign make_rpt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    band_d   = band_q;
    mute_d   = mute_q;
    make_vld = 1'b0;
    make_key = {1'b0, data_i};
`ifdef KEY_REPEAT_FILTER_EN
    held_d   = held_q;
    brk_vld  = 1'b0;
    brk_key  = {1'b0, data_i};
`endif
    // A byte arriving on the expiry cycle wins over the timeout.
    if (rx_listo) begin
      unique case (state_q)
        StIdle: begin
          case (data_i)
            SC_BRK: state_d = StBrk;
            SC_EXT: state_d = StExt;
            SC_K1, SC_K2, SC_K3, SC_K0: make_vld = 1'b1;
            default: ;
          endcase
        end
        StBrk: begin
          state_d = StIdle;
`ifdef KEY_REPEAT_FILTER_EN
          brk_vld = 1'b1;
`endif
        end
        StExt: begin
          state_d  = StIdle;
          make_key = {1'b1, data_i};
          if (data_i == SC_BRK) begin
            state_d = StExtBrk;
          end else if ((data_i == SC_UP) || (data_i == SC_DN)) begin
            make_vld = 1'b1;
          end
        end
        StExtBrk: begin
          state_d = StIdle;
`ifdef KEY_REPEAT_FILTER_EN
          brk_vld = 1'b1;
          brk_key = {1'b1, data_i};
`endif
        end
      endcase
    end else if ((state_q != StIdle) && expire) begin
      state_d = StIdle;
    end

    if (make_vld && !make_rpt) begin
`ifdef KEY_REPEAT_FILTER_EN
      held_d = make_key;
`endif
      case (make_key)
        {1'b0, SC_K1}: begin band_d = BAND1; mute_d = 1'b0; end
        {1'b0, SC_K2}: begin band_d = BAND2; mute_d = 1'b0; end
        {1'b0, SC_K3}: begin band_d = BAND3; mute_d = 1'b0; end
        {1'b0, SC_K0}: mute_d = ~mute_q;
        {1'b1, SC_UP}: band_d = band_up(band_q);
        {1'b1, SC_DN}: band_d = band_dn(band_q);
        default: ;
      endcase
    end

`ifdef KEY_REPEAT_FILTER_EN
    // Releasing the held key re-arms it; held=0 never matches a real make key.
    if (brk_vld && (brk_key == held_q)) begin
      held_d = '0;
    end
`endif

    chg_d = (band_d != band_q) || (mute_d != mute_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      band_q  <= BAND1;
      mute_q  <= 1'b0;
      chg_q   <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
      held_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
      mute_q  <= mute_d;
      chg_q   <= chg_d;
`ifdef KEY_REPEAT_FILTER_EN
      held_q  <= held_d;
`endif
    end
  end

  assign band_o = band_q;
  assign mute_o = mute_q;
  assign chg_o  = chg_q;

endmodule

// File: tb/tb_ps2_band_selector.sv
// tb_ps2_band_selector: scoreboard bench for ps2_band_selector with a keyboard-level model.
module tb_ps2_band_selector;

  localparam int unsigned TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_listo;
  logic [7:0] data;
  logic [1:0] band;
  logic       mute;
  logic       chg;

  ps2_band_selector #(
    .TIMEOUT (TIMEOUT),
    .TO_W    ($clog2(TIMEOUT))
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .rx_listo (rx_listo),
    .data_i   (data),
    .band_o   (band),
    .mute_o   (mute),
    .chg_o    (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected {band, mute} for each change the model predicts, in order.
  logic [2:0] exp_q[$];
  logic [2:0] prev_out = 3'b000;
  logic [2:0] exp_item;

  // Keyboard-level model: pending prefixes and quiet cycles since the last byte.
  int m_band = 0;
  bit m_mute = 1'b0;
  bit p_brk = 1'b0;
  bit p_ext = 1'b0;
  int gap = 0;
`ifdef KEY_REPEAT_FILTER_EN
  bit [8:0] m_held = '0;
`endif

  function automatic void model_reset();
    m_band = 0;
    m_mute = 1'b0;
    p_brk  = 1'b0;
    p_ext  = 1'b0;
    gap    = 0;
`ifdef KEY_REPEAT_FILTER_EN
    m_held = '0;
`endif
    exp_q.delete();
  endfunction

  function automatic void model_make(bit ext, logic [7:0] b);
    int nb = m_band;
    bit nm = m_mute;
`ifdef KEY_REPEAT_FILTER_EN
    if (m_held == {ext, b}) return;
    m_held = {ext, b};
`endif
    if (!ext) begin
      if (b == 8'h16) begin nb = 0; nm = 1'b0; end
      else if (b == 8'h1E) begin nb = 1; nm = 1'b0; end
      else if (b == 8'h26) begin nb = 2; nm = 1'b0; end
      else if (b == 8'h45) nm = !m_mute;
    end else if (b == 8'h75) begin
      nb = (m_band + 1) % 3;
    end else begin
      nb = (m_band + 2) % 3;
    end
    if (nb != m_band || nm != m_mute) begin
      exp_q.push_back({2'(nb), nm});
      m_band = nb;
      m_mute = nm;
    end
  endfunction

  function automatic void model_byte(logic [7:0] b);
    // A prefix survives at most TIMEOUT-1 quiet cycles.
    if (gap >= int'(TIMEOUT)) begin
      p_brk = 1'b0;
      p_ext = 1'b0;
    end
    gap = 0;
    if (p_brk) begin
`ifdef KEY_REPEAT_FILTER_EN
      if (m_held == {p_ext, b}) m_held = '0;
`endif
      p_brk = 1'b0;
      p_ext = 1'b0;
    end else if (p_ext) begin
      if (b == 8'hF0) begin
        p_brk = 1'b1;
      end else begin
        p_ext = 1'b0;
        if (b == 8'h75 || b == 8'h72) model_make(1'b1, b);
      end
    end else if (b == 8'hF0) begin
      p_brk = 1'b1;
    end else if (b == 8'hE0) begin
      p_ext = 1'b1;
    end else if (b == 8'h16 || b == 8'h1E || b == 8'h26 || b == 8'h45) begin
      model_make(1'b0, b);
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs change 1 ns after the rising edge.
  task automatic cycle(input bit stb, input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_listo = stb;
    data     = stb ? b : 8'($urandom);
    if (stb) model_byte(b);
    else gap++;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic settle(input string name);
    quiet(2);
    @(negedge clk);
    check({name, " band"}, int'(band), m_band);
    check({name, " mute"}, int'(mute), int'(m_mute));
    check({name, " pending changes"}, exp_q.size(), 0);
  endtask

  // Monitor: every chg_o pulse must match the next predicted change; no silent changes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out = 3'b000;
    end else begin
      checks++;
      if (chg) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL chg_unexpected: got pulse with band=%0d mute=%0d, expected no pulse",
                   band, mute);
        end else begin
          exp_item = exp_q.pop_front();
          if ({band, mute} !== exp_item) begin
            failures++;
            $display("FAIL chg_value: got band=%0d mute=%0d, expected band=%0d mute=%0d",
                     band, mute, exp_item[2:1], exp_item[0]);
          end
        end
      end else if ({band, mute} !== prev_out) begin
        failures++;
        $display("FAIL silent_change: got band=%0d mute=%0d without chg_o, expected %0d/%0d",
                 band, mute, prev_out[2:1], prev_out[0]);
      end
      prev_out = {band, mute};
    end
  end

  initial begin
    int pick;
    logic [7:0] b;
    logic [7:0] tbl[8];
    tbl = '{8'hF0, 8'hE0, 8'h16, 8'h1E, 8'h26, 8'h45, 8'h75, 8'h72};

    rst_n    = 1'b0;
    rx_listo = 1'b0;
    data     = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset band", int'(band), 0);
    check("reset mute", int'(mute), 0);
    check("reset chg", int'(chg), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain make, then a break of the same key.
    send(8'h1E);
    settle("make 2");
    send(8'hF0); send(8'h1E);
    settle("break 2");

    // Up/down wrap-around.
    send(8'h26);
    settle("make 3");
    send(8'hE0); send(8'h75);
    settle("up wrap");
    send(8'hE0); send(8'h72);
    settle("down wrap");

    // Mute toggling, then a band key clears mute.
    send(8'h45);
    settle("mute on");
    send(8'hF0); send(8'h45);
    send(8'h45);
    settle("mute off");
    send(8'h45);
    send(8'hF0); send(8'h45);
    send(8'h26);
    settle("band clears mute");

    // Prefix timeout: expired prefix, then a byte exactly on the expiry cycle.
    send(8'h1E);
    send(8'hE0); quiet(TIMEOUT); send(8'h75);
    settle("timeout drops up");
    send(8'hE0); quiet(TIMEOUT - 1); send(8'h75);
    settle("byte on expiry");
    send(8'hF0); quiet(TIMEOUT - 1); send(8'h26);
    settle("break on expiry");

    // Typematic repeats of '0'.
    send(8'h45); send(8'h45); send(8'h45);
    settle("repeat 0");
    send(8'hF0); send(8'h45); send(8'h45);
    settle("release and repress 0");

    // Asynchronous reset in the middle of a prefix sequence.
    send(8'h26); send(8'h45);
    settle("pre-reset");
    send(8'hE0);
    quiet(5);
    #3;
    rst_n    = 1'b0;
    rx_listo = 1'b0;
    #1;
    check("async reset band", int'(band), 0);
    check("async reset mute", int'(mute), 0);
    check("async reset chg", int'(chg), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h75);
    settle("lone up after reset");

    // Randomized keyboard traffic with occasional long pauses around the timeout.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        quiet(int'(TIMEOUT) - 2 + int'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 1) == 0) begin
        quiet(1);
      end else begin
        pick = int'($urandom_range(0, 9));
        b = (pick < 8) ? tbl[pick] : 8'($urandom);
        send(b);
      end
    end
    settle("random end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
